counter_mem_uart_tx: RTL

//  Downstream stage of the counter/memory data source.
//  - Captures each 8-bit word presented with the source's enable strobe.
//  - Buffers captured words in a small FIFO.
//  - Transmits them serially as 8N1 UART frames, LSB first, for off-chip observation.
//  - Absorbs bursts from the source; reports overflow when the FIFO cannot keep up.

---
 rtl/counter_mem_uart_tx_if.sv | 28 ++
 rtl/counter_mem_uart_tx.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/counter_mem_uart_tx_if.sv
// Bus bundle between the counter/memory source and the UART transmit stage.
interface counter_mem_uart_tx_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              enable;
    logic [DATA_W-1:0] i_data;
    logic              o_tx;
    logic              o_busy;
    logic              o_full;
    logic              o_empty;
    logic [CNT_W-1:0]  o_count;
    logic              o_overflow;

    // Source side: drives write strobe and data, observes status and line.
    modport master (
        output enable, i_data,
        input  o_tx, o_busy, o_full, o_empty, o_count, o_overflow
    );

    // Transmitter side.
    modport slave (
        input  enable, i_data,
        output o_tx, o_busy, o_full, o_empty, o_count, o_overflow
    );
endinterface

// File: rtl/counter_mem_uart_tx.sv
// Captures source words into a FIFO and sends them as 8N1 UART frames, LSB first.
module counter_mem_uart_tx #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    counter_mem_uart_tx_if.slave  bus
);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W  = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count, count_n;
    logic              full, empty, overflow;
    logic              push, pop;
    logic [DATA_W-1:0] shreg;
    logic              tx, busy;

    state_t            state, state_n;
    logic [BAUD_W-1:0] baud, baud_n;
    logic [BIT_W-1:0]  bit_idx, bit_idx_n;
    logic              baud_last;

    assign push      = bus.enable && !full;
    assign baud_last = (baud == BAUD_W'(CLKS_PER_BIT - 1));

    // Storage array; pointers are reset, contents need not be.
    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= bus.i_data;
    end

    // Next occupancy from this cycle's push/pop pair.
    always_comb begin
        count_n = count;
        case ({push, pop})
            2'b10:   count_n = count + CNT_W'(1);
            2'b01:   count_n = count - CNT_W'(1);
            default: count_n = count;
        endcase
    end

    // FIFO pointers, occupancy flags and sticky overflow.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (bus.enable && full) overflow <= 1'b1;
            count <= count_n;
            full  <= (count_n == CNT_W'(DEPTH));
            empty <= (count_n == '0);
        end
    end

    // TX state register with baud and bit counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_idx <= bit_idx_n;
        end
    end

    // TX next-state logic; baud counter clears on every state change.
    always_comb begin
        state_n   = state;
        baud_n    = baud + BAUD_W'(1);
        bit_idx_n = bit_idx;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                baud_n    = '0;
                bit_idx_n = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = START;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_n  = '0;
                    state_n = DATA;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_n = '0;
                    if (bit_idx == BIT_W'(DATA_W - 1)) begin
                        bit_idx_n = '0;
                        state_n   = STOP;
                    end else begin
                        bit_idx_n = bit_idx + BIT_W'(1);
                    end
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_n  = '0;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                baud_n  = '0;
            end
        endcase
    end

    // Shift register holds the word being framed; loaded on pop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) shreg <= '0;
        else if (pop) shreg <= mem[rd_ptr];
    end

    // Registered line and busy, one cycle behind the state so o_tx never glitches.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tx   <= 1'b1;
            busy <= 1'b0;
        end else begin
            busy <= (state != IDLE);
            case (state)
                START:   tx <= 1'b0;
                DATA:    tx <= shreg[bit_idx];
                default: tx <= 1'b1;
            endcase
        end
    end

    assign bus.o_tx       = tx;
    assign bus.o_busy     = busy;
    assign bus.o_full     = full;
    assign bus.o_empty    = empty;
    assign bus.o_count    = count;
    assign bus.o_overflow = overflow;
endmodule
